anton_neopixel_bus_host: RTL and testbench
==========================================

# anton_neopixel_bus_host

Byte-stream bus initiator that drives the NeoPixel register block's byte bus (busAddr/busDataIn/busWrite/busRead/busDataOut/busReady). It decodes a framed command stream into single-cycle register-block write and read transactions, with optional address auto-increment. It returns read data and status bytes on a response stream. It sits between a host link (UART/SPI byte front end) and the register block.

## Interface
- ACK_BYTE, 8'h5A, status byte emitted after a successful write command
- ERR_BYTE, 8'hEE, status byte emitted on bad opcode or bus timeout
- READY_TIMEOUT, 255, max cycles to wait for busReady before aborting (1..65535)
- busClk  in  1  single clock; all logic on rising edge
- busReset  in  1  synchronous, active-high reset
- cmdData  in  8  command stream byte
- cmdValid  in  1  cmdData valid
- cmdReady  out  1  block accepts cmdData this cycle (handshake = cmdValid & cmdReady at edge)
- rspData  out  8  response byte
- rspValid  out  1  rspData valid, held until accepted
- rspReady  in  1  consumer accepts rspData
- busAddr  out  18  transaction address; [17:16] region, [15:0] offset
- busDataIn  out  8  write data to register block
- busWrite  out  1  one-cycle write strobe
- busRead  out  1  one-cycle read strobe
- busDataOut  in  8  read data from register block
- busReady  in  1  responder ready
- busy  out  1  high in every state except IDLE

## Operation
- Frame: OP, ADDR_H, ADDR_L, LEN, then LEN+1 data bytes for writes (none for reads).
- OP: [7]=read, [6]=auto-increment, [5:2] must be 0, [1:0]=region → busAddr[17:16]. ADDR_H/ADDR_L form busAddr[15:0]. Transfers = LEN+1 (1..256).
- States: IDLE, ADDR_H, ADDR_L, LEN, WR_DATA, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_PUSH, STATUS.
- IDLE: cmdReady=1. On handshake latch OP. If OP[5:2]≠0, go to STATUS with ERR_BYTE; the rest of the frame is then parsed as new frames. Otherwise go to ADDR_H.
- ADDR_H → ADDR_L → LEN: cmdReady=1, one byte each. After LEN, go to WR_DATA (write) or RD_ISSUE (read).
- WR_DATA: cmdReady=1. On handshake latch the byte into busDataIn and go to WR_ISSUE.
- WR_ISSUE: on the first edge with busReady=1, busWrite=1 for exactly one cycle. After the strobe:
  - Advance the address.
  - Decrement the remaining count.
  - Go to WR_DATA, or to STATUS with ACK_BYTE after the last transfer.
- RD_ISSUE: on the first edge with busReady=1, busRead=1 for one cycle, then go to RD_WAIT.
- RD_WAIT: at the first edge with busReady=1 (earliest: the edge ending the cycle after the strobe), capture busDataOut into rspData, set rspValid, go to RD_PUSH.
- RD_PUSH: on rspReady, drop rspValid, advance the address, then go to RD_ISSUE or IDLE. Reads emit no ACK.
- STATUS: rspData = status, rspValid=1 until rspReady, then go to IDLE.
- Address advance: if OP[6]=1, busAddr[15:0]+1 mod 2^16 (0xFFFF wraps to 0x0000); busAddr[17:16] never changes. If OP[6]=0, the address stays constant.
- Timeout: a counter resets on entry to WR_ISSUE/RD_ISSUE/RD_WAIT. If busReady stays low for READY_TIMEOUT consecutive edges, abort to STATUS with ERR_BYTE.
  - Write abort: any remaining write data is left unconsumed in the stream.
  - Read abort: the remaining reads are dropped.

## Timing
- Reset values: cmdReady=0 while busReset=1; it becomes 1 in the first cycle after release (IDLE).
- All other outputs are registered and reset to 0: rspData, rspValid, busAddr, busDataIn, busWrite, busRead, busy.
- busAddr and busDataIn are stable throughout the busWrite/busRead cycle and the cycle after.
- Write latency: data handshake at edge N → busWrite high in cycle N+1 (busReady=1). Back-to-back stream gives one write per 2 cycles.
- Read latency: busRead in cycle R → rspValid high from cycle R+2 (busReady=1).
- busWrite and busRead are never high simultaneously; never high for two consecutive cycles.
- cmdReady=0 in WR_ISSUE, RD_*, STATUS; no byte is consumed there.
- Reset mid-operation:
  - Immediate return to IDLE.
  - A pending strobe is suppressed.
  - rspValid is cleared even if unaccepted.
  - The partial frame is discarded.

## Test plan
- Write frame 0x43,0x00,0x02,0x01,0x11,0x22 (region 3, autoinc) → busWrite at addr 0x30002 data 0x11, then 0x30003 data 0x22; rspData=0x5A.
- Read frame 0x83,0x00,0x02,0x00 with responder returning 0x7F → one busRead at 0x30002; rspData=0x7F, two cycles after the strobe; no ACK.
- Autoinc wrap: write OP 0x42, addr 0xFFFF, LEN 1 → writes at 0x2FFFF then 0x20000. With OP 0x02 both writes go to 0x2FFFF.
- Bad opcode 0x04 → ERR_BYTE 0xEE, no bus strobe, back in IDLE. Hold rspReady=0 for 10 cycles → rspValid and 0xEE held, cmdReady=0.
- busReady low forever during a read with READY_TIMEOUT=8 → no busRead; 0xEE after 8 edges. busReady low 3 cycles then high → read completes normally.
- Assert busReset during RD_WAIT → all outputs 0 next cycle; a fresh write frame afterwards completes with 0x5A.

Source files
------------

// File: rtl/anton_neopixel_bus_host.sv
// Byte-stream bus initiator for the NeoPixel register block.
// Ports: busClk/busReset, cmd byte stream in, rsp byte stream out,
// busAddr/busDataIn/busWrite/busRead/busDataOut/busReady, busy.
module anton_neopixel_bus_host #(
  parameter logic [7:0]  ACK_BYTE      = 8'h5A,
  parameter logic [7:0]  ERR_BYTE      = 8'hEE,
  parameter int unsigned READY_TIMEOUT = 255
) (
  input  logic        busClk,
  input  logic        busReset,
  input  logic [7:0]  cmdData,
  input  logic        cmdValid,
  output logic        cmdReady,
  output logic [7:0]  rspData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [17:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut,
  input  logic        busReady,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN,
    S_WR_DATA,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_PUSH,
    S_STATUS
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(READY_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        rd_op_q, rd_op_d;
  logic        inc_q, inc_d;
  logic [17:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] tmo_q, tmo_d;
  logic        first_q, first_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [7:0]  rsp_q, rsp_d;
  logic        rspv_q, rspv_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        hs;
  logic [17:0] addr_nx;

  assign accept = (state_q == S_IDLE)   ||
                  (state_q == S_ADDR_H) ||
                  (state_q == S_ADDR_L) ||
                  (state_q == S_LEN)    ||
                  (state_q == S_WR_DATA);
  assign cmdReady = accept & ~busReset;
  assign hs       = cmdValid & cmdReady;

  // Region bits never move; offset wraps within 64K.
  assign addr_nx = inc_q ?
    {addr_q[17:16], addr_q[15:0] + 16'd1} : addr_q;

  always_comb begin
    state_d = state_q;
    rd_op_d = rd_op_q;
    inc_d   = inc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    first_d = first_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    rsp_d   = rsp_q;
    rspv_d  = rspv_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          rd_op_d = cmdData[7];
          inc_d   = cmdData[6];
          if (|cmdData[5:2]) begin
            rsp_d   = ERR_BYTE;
            rspv_d  = 1'b1;
            state_d = S_STATUS;
          end else begin
            addr_d[17:16] = cmdData[1:0];
            state_d       = S_ADDR_H;
          end
        end
      end
      S_ADDR_H: begin
        if (hs) begin
          addr_d[15:8] = cmdData;
          state_d      = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (hs) begin
          addr_d[7:0] = cmdData;
          state_d     = S_LEN;
        end
      end
      S_LEN: begin
        if (hs) begin
          rem_d   = cmdData;
          first_d = 1'b1;
          tmo_d   = '0;
          state_d = rd_op_q ? S_RD_ISSUE : S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        // The previous write's address advance is applied here so
        // address and data hold through the cycle after the strobe.
        if (hs) begin
          data_d  = cmdData;
          first_d = 1'b0;
          if (!first_q) addr_d = addr_nx;
          tmo_d   = '0;
          wr_d    = busReady;
          state_d = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        if (wr_q) begin
          if (rem_q == 8'd0) begin
            rsp_d   = ACK_BYTE;
            rspv_d  = 1'b1;
            state_d = S_STATUS;
          end else begin
            rem_d   = rem_q - 8'd1;
            state_d = S_WR_DATA;
          end
        end else if (busReady) begin
          wr_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          rsp_d   = ERR_BYTE;
          rspv_d  = 1'b1;
          state_d = S_STATUS;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RD_ISSUE: begin
        if (busReady) begin
          rd_d    = 1'b1;
          tmo_d   = '0;
          state_d = S_RD_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          rsp_d   = ERR_BYTE;
          rspv_d  = 1'b1;
          state_d = S_STATUS;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RD_WAIT: begin
        // The edge ending the strobe cycle is never a capture edge.
        if (rd_q) begin
          tmo_d = '0;
        end else if (busReady) begin
          rsp_d   = busDataOut;
          rspv_d  = 1'b1;
          state_d = S_RD_PUSH;
        end else if (tmo_q == TMO_LAST) begin
          rsp_d   = ERR_BYTE;
          rspv_d  = 1'b1;
          state_d = S_STATUS;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RD_PUSH: begin
        if (rspReady) begin
          rspv_d = 1'b0;
          addr_d = addr_nx;
          if (rem_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            rem_d   = rem_q - 8'd1;
            tmo_d   = '0;
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_STATUS: begin
        if (rspReady) begin
          rspv_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge busClk) begin
    if (busReset) begin
      state_q <= S_IDLE;
      rd_op_q <= 1'b0;
      inc_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      first_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rsp_q   <= '0;
      rspv_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_op_q <= rd_op_d;
      inc_q   <= inc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      first_q <= first_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rsp_q   <= rsp_d;
      rspv_q  <= rspv_d;
      busy_q  <= busy_d;
    end
  end

  assign rspData   = rsp_q;
  assign rspValid  = rspv_q;
  assign busAddr   = addr_q;
  assign busDataIn = data_q;
  assign busWrite  = wr_q;
  assign busRead   = rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_anton_neopixel_bus_host.sv
// Directed testbench for anton_neopixel_bus_host.
// Frames are pushed byte by byte; a negedge monitor logs strobes.
module tb_anton_neopixel_bus_host;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmdData;
  logic        cmdValid;
  logic        cmdReady;
  logic [7:0]  rspData;
  logic        rspValid;
  logic        rspReady;
  logic [17:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite;
  logic        busRead;
  logic [7:0]  busDataOut;
  logic        busReady;
  logic        busy;

  anton_neopixel_bus_host #(
    .ACK_BYTE(8'h5A),
    .ERR_BYTE(8'hEE),
    .READY_TIMEOUT(8)
  ) dut (
    .busClk(clk),
    .busReset(rst),
    .cmdData(cmdData),
    .cmdValid(cmdValid),
    .cmdReady(cmdReady),
    .rspData(rspData),
    .rspValid(rspValid),
    .rspReady(rspReady),
    .busAddr(busAddr),
    .busDataIn(busDataIn),
    .busWrite(busWrite),
    .busRead(busRead),
    .busDataOut(busDataOut),
    .busReady(busReady),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cyc;
  int rv_cyc;
  int both_n = 0;
  int consec_n = 0;
  int unstable_n = 0;
  logic prev_stb = 1'b0;
  logic prev_rv = 1'b0;
  logic [17:0] prev_addr;
  logic [7:0]  prev_data;
  logic [25:0] wq[$];
  int          wcyc[$];
  logic [17:0] rq[$];
  int          rcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busWrite) begin
      wq.push_back({busAddr, busDataIn});
      wcyc.push_back(cyc);
    end
    if (busRead) begin
      rq.push_back(busAddr);
      rcyc.push_back(cyc);
    end
    if (busWrite && busRead) both_n++;
    if ((busWrite || busRead) && prev_stb) consec_n++;
    if (prev_stb && busy &&
        (busAddr !== prev_addr || busDataIn !== prev_data))
      unstable_n++;
    if (rspValid && !prev_rv) rv_cyc = cyc;
    prev_rv   = rspValid;
    prev_stb  = busWrite | busRead;
    prev_addr = busAddr;
    prev_data = busDataIn;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    cmdData  = b;
    cmdValid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!cmdReady && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("send_stall", k, 0);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    hs_cyc   = cyc;
  endtask

  task automatic hdr(input logic [7:0] op, input logic [7:0] ah,
                     input logic [7:0] al, input logic [7:0] len);
    send(op);
    send(ah);
    send(al);
    send(len);
  endtask

  task automatic get_rsp(input string tag, input logic [7:0] exp);
    int k;
    k = 0;
    while (!rspValid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) chk({tag, "_timeout"}, k, 0);
    chk(tag, rspData, exp);
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
  endtask

  task automatic clear_logs();
    wq.delete();
    wcyc.delete();
    rq.delete();
    rcyc.delete();
  endtask

  int h0;
  int nw;
  int nr;

  initial begin
    rst        = 1'b1;
    cmdData    = 8'h00;
    cmdValid   = 1'b0;
    rspReady   = 1'b0;
    busDataOut = 8'h00;
    busReady   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmdReady", {31'd0, cmdReady}, 0);
    chk("rst_outs",
        {rspData, rspValid, busDataIn, busWrite, busRead, busy}, 0);
    chk("rst_addr", {14'd0, busAddr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmdReady", {31'd0, cmdReady}, 1);
    @(posedge clk); #1;

    // Region 3 auto-increment write of two bytes.
    clear_logs();
    hdr(8'h43, 8'h00, 8'h02, 8'h01);
    send(8'h11);
    h0 = hs_cyc;
    send(8'h22);
    get_rsp("wr_ack", 8'h5A);
    chk("wr_cnt", wq.size(), 2);
    chk("wr0", {6'd0, wq[0]}, {6'd0, 18'h30002, 8'h11});
    chk("wr1", {6'd0, wq[1]}, {6'd0, 18'h30003, 8'h22});
    chk("wr_lat", wcyc[0] - h0, 0);
    chk("wr_pace", wcyc[1] - wcyc[0], 2);

    // Single read returning 0x7F; no ACK follows.
    clear_logs();
    busDataOut = 8'h7F;
    hdr(8'h83, 8'h00, 8'h02, 8'h00);
    get_rsp("rd_data", 8'h7F);
    chk("rd_cnt", rq.size(), 1);
    chk("rd_addr", {14'd0, rq[0]}, {14'd0, 18'h30002});
    chk("rd_lat", rv_cyc - rcyc[0], 2);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_no_ack", {30'd0, rspValid, busy}, 0);

    // Offset wrap with and without auto-increment.
    clear_logs();
    hdr(8'h42, 8'hFF, 8'hFF, 8'h01);
    send(8'hA1);
    send(8'hA2);
    get_rsp("wrap_ack", 8'h5A);
    chk("wrap0", {6'd0, wq[0]}, {6'd0, 18'h2FFFF, 8'hA1});
    chk("wrap1", {6'd0, wq[1]}, {6'd0, 18'h20000, 8'hA2});
    clear_logs();
    hdr(8'h02, 8'hFF, 8'hFF, 8'h01);
    send(8'hB1);
    send(8'hB2);
    get_rsp("noinc_ack", 8'h5A);
    chk("noinc0", {6'd0, wq[0]}, {6'd0, 18'h2FFFF, 8'hB1});
    chk("noinc1", {6'd0, wq[1]}, {6'd0, 18'h2FFFF, 8'hB2});

    // Bad opcode, response held back by the consumer.
    clear_logs();
    send(8'h04);
    repeat (10) @(posedge clk);
    #1;
    chk("bad_hold",
        {22'd0, rspValid, rspData, cmdReady}, {22'd0, 1'b1, 8'hEE, 1'b0});
    get_rsp("bad_err", 8'hEE);
    @(negedge clk);
    chk("bad_idle", {30'd0, busy, cmdReady}, 1);
    chk("bad_nostb", wq.size() + rq.size(), 0);
    @(posedge clk); #1;

    // Responder never ready: abort after eight edges.
    clear_logs();
    busReady = 1'b0;
    hdr(8'h81, 8'h00, 8'h10, 8'h00);
    repeat (7) @(posedge clk);
    #1;
    chk("tmo_early", {31'd0, rspValid}, 0);
    @(posedge clk); #1;
    chk("tmo_err", {23'd0, rspValid, rspData}, {23'd0, 1'b1, 8'hEE});
    get_rsp("tmo_rsp", 8'hEE);
    chk("tmo_nord", rq.size(), 0);
    busReady = 1'b1;

    // Responder late by three cycles.
    clear_logs();
    busDataOut = 8'h3C;
    busReady   = 1'b0;
    hdr(8'h80, 8'h00, 8'h20, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    busReady = 1'b1;
    get_rsp("late_data", 8'h3C);
    chk("late_addr", {14'd0, rq[0]}, {14'd0, 18'h00020});

    // Reset while waiting for read data, then a fresh write.
    clear_logs();
    hdr(8'h81, 8'h00, 8'h05, 8'h00);
    @(posedge clk); #1;
    chk("rw_strobe", {31'd0, busRead}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rw_rst_outs",
        {rspData, rspValid, busDataIn, busWrite, busRead, busy,
         cmdReady}, 0);
    chk("rw_rst_addr", {14'd0, busAddr}, 0);
    rst = 1'b0;
    clear_logs();
    hdr(8'h41, 8'h00, 8'h40, 8'h00);
    send(8'h55);
    get_rsp("post_rst_ack", 8'h5A);
    chk("post_rst_wr", {6'd0, wq[0]}, {6'd0, 18'h10040, 8'h55});

    nw = both_n;
    nr = consec_n;
    chk("never_both", nw, 0);
    chk("never_consec", nr, 0);
    chk("addr_stable", unstable_n, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
